// File: rtl/tx_trn_framer.sv
// Transmit TRN framer: alternating pre-boundary run, one repeated boundary symbol,
// alternating post-boundary run, then payload bits, one symbol per sym_en strobe.
module tx_trn_framer #(
  parameter int MAX_TRN_WIDTH = 8,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sym_en,
  input  logic [MAX_TRN_WIDTH-1:0] TX_PRE_LEN,
  input  logic [MAX_TRN_WIDTH-1:0] TX_POST_LEN,
  input  logic [LEN_WIDTH-1:0]     TX_DATA_LEN,
  input  logic                     start,
  input  logic                     data_in,
  input  logic                     data_vld,
  output logic                     data_rdy,
  output logic                     BPSK,
  output logic                     BPSK_vld,
  output logic                     HDR_pos,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);

  typedef enum logic [2:0] {IDLE, ARM, PRE, POST, DATA} state_t;

  localparam logic [MAX_TRN_WIDTH-1:0] TRN_ONE = MAX_TRN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE = LEN_WIDTH'(1);

  state_t                   r_state, w_state;
  logic [MAX_TRN_WIDTH-1:0] r_preLen, w_preLen, r_postLen, w_postLen;
  logic [MAX_TRN_WIDTH-1:0] r_trnCnt, w_trnCnt;
  logic [LEN_WIDTH-1:0]     r_dataLen, w_dataLen, r_dataCnt, w_dataCnt;
  logic                     r_phase, w_phase;
  logic                     r_bpsk, w_bpsk, r_bpskVld, w_bpskVld, r_hdrPos, w_hdrPos;
  logic                     r_busy, w_busy, r_done, w_done, r_underrun, w_underrun;

  assign data_rdy = (r_state == DATA) & sym_en;
  assign BPSK     = r_bpsk;
  assign BPSK_vld = r_bpskVld;
  assign HDR_pos  = r_hdrPos;
  assign busy     = r_busy;
  assign done     = r_done;
  assign underrun = r_underrun;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_preLen   <= '0;
      r_postLen  <= '0;
      r_dataLen  <= '0;
      r_trnCnt   <= '0;
      r_dataCnt  <= '0;
      r_phase    <= 1'b0;
      r_bpsk     <= 1'b0;
      r_bpskVld  <= 1'b0;
      r_hdrPos   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_preLen   <= w_preLen;
      r_postLen  <= w_postLen;
      r_dataLen  <= w_dataLen;
      r_trnCnt   <= w_trnCnt;
      r_dataCnt  <= w_dataCnt;
      r_phase    <= w_phase;
      r_bpsk     <= w_bpsk;
      r_bpskVld  <= w_bpskVld;
      r_hdrPos   <= w_hdrPos;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_underrun <= w_underrun;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_preLen   = r_preLen;
    w_postLen  = r_postLen;
    w_dataLen  = r_dataLen;
    w_trnCnt   = r_trnCnt;
    w_dataCnt  = r_dataCnt;
    w_phase    = r_phase;
    w_bpsk     = r_bpsk;
    w_bpskVld  = r_bpskVld;
    w_hdrPos   = r_hdrPos;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_underrun = 1'b0;

    // busy still high during the done cycle, which also blocks a start arriving then
    if (r_done) w_busy = 1'b0;

    case (r_state)
      IDLE: begin
        if (sym_en) begin
          w_bpsk    = 1'b0;
          w_bpskVld = 1'b0;
          w_hdrPos  = 1'b0;
        end
        if (start && !r_busy) begin
          w_preLen  = (TX_PRE_LEN == '0) ? TRN_ONE : TX_PRE_LEN;
          w_postLen = (TX_POST_LEN == '0) ? TRN_ONE : TX_POST_LEN;
          w_dataLen = TX_DATA_LEN;
          w_trnCnt  = '0;
          w_dataCnt = '0;
          w_phase   = 1'b0;
          w_busy    = 1'b1;
          w_state   = ARM;
        end
      end
      ARM, PRE: begin
        if (sym_en) begin
          w_bpsk    = r_phase;
          w_bpskVld = 1'b1;
          w_hdrPos  = 1'b1;
          // the last pre symbol keeps the phase so the boundary repeats it
          if (r_trnCnt == r_preLen - TRN_ONE) begin
            w_trnCnt = '0;
            w_state  = POST;
          end else begin
            w_trnCnt = r_trnCnt + TRN_ONE;
            w_phase  = ~r_phase;
            w_state  = PRE;
          end
        end
      end
      POST: begin
        if (sym_en) begin
          w_bpsk    = r_phase;
          w_bpskVld = 1'b1;
          w_hdrPos  = 1'b0;
          w_phase   = ~r_phase;
          if (r_trnCnt == r_postLen - TRN_ONE) begin
            w_trnCnt = '0;
            if (r_dataLen == '0) begin
              w_done  = 1'b1;
              w_state = IDLE;
            end else begin
              w_state = DATA;
            end
          end else begin
            w_trnCnt = r_trnCnt + TRN_ONE;
          end
        end
      end
      DATA: begin
        if (sym_en) begin
          w_bpsk     = data_in & data_vld;
          w_bpskVld  = 1'b1;
          w_hdrPos   = 1'b0;
          w_underrun = ~data_vld;
          if (r_dataCnt == r_dataLen - LEN_ONE) begin
            w_dataCnt = '0;
            w_done    = 1'b1;
            w_state   = IDLE;
          end else begin
            w_dataCnt = r_dataCnt + LEN_ONE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

endmodule

// File: doc/tx_trn_framer.md
# tx_trn_framer

Transmit-side packet framer for the BPSK link. It emits the TRN field that the receive boundary detector locks onto. The field is an alternating pre-boundary run, one deliberately repeated symbol (the boundary), and an alternating post-boundary run. Payload bits from an upstream source follow, one bit per symbol strobe. It sits between the payload source and the BPSK modulator/upsampler.

## Interface
- `MAX_TRN_WIDTH`, default 8: width of the TRN length configuration inputs and counters.
- `LEN_WIDTH`, default 16: width of the payload length input and counter.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset. Sampled on `clk` rising edge; 0 = reset.
- `sym_en` in 1: symbol strobe, one-cycle pulse per symbol period. All state/output updates occur only on `sym_en` cycles, except `start` capture and reset.
- `TX_PRE_LEN` in MAX_TRN_WIDTH: symbols before the boundary. 0 is treated as 1.
- `TX_POST_LEN` in MAX_TRN_WIDTH: symbols from the boundary symbol (inclusive) to the end of TRN. 0 is treated as 1.
- `TX_DATA_LEN` in LEN_WIDTH: payload bits per packet. 0 is legal: no payload.
- `start` in 1: packet request. Honoured only in IDLE.
- `data_in` in 1: payload bit.
- `data_vld` in 1: `data_in` valid.
- `data_rdy` out 1: combinational, = (state==DATA) & `sym_en`. Bit is consumed in that cycle.
- `BPSK` out 1: symbol bit to the modulator, registered.
- `BPSK_vld` out 1: `BPSK` carries a frame symbol, registered.
- `HDR_pos` out 1: high while pre-boundary symbols are on `BPSK`, registered.
- `busy` out 1: high from `start` acceptance until return to IDLE.
- `done` out 1: one-`clk` pulse when the last symbol of the packet has been issued.
- `underrun` out 1: one-`clk` pulse when a payload symbol was due and `data_vld` was 0.

## Operation
- States: IDLE, ARM, PRE, POST, DATA.
- Reset value of every output is 0. The state is IDLE and all counters and the phase bit are 0.
- **IDLE:** on `start`=1, latch the three lengths (zero PRE/POST lengths forced to 1), set `busy`=1, phase=0, and go to ARM. Lengths are not resampled until the next packet.
- **ARM:** waits for the next `sym_en`, then enters PRE on the same edge as the first symbol is driven.
- **PRE:** each `sym_en` drives `BPSK`=phase, `BPSK_vld`=1, `HDR_pos`=1, toggles phase and increments cnt. After PRE_LEN symbols, go to POST.
  - Symbol k of PRE = k mod 2.
- **POST:**
  - The first POST symbol repeats the last PRE symbol, (PRE_LEN-1) mod 2. This is the boundary. The phase is not toggled before it; it is toggled after each POST symbol.
  - `HDR_pos`=0 from the first POST symbol onward.
  - After POST_LEN symbols, go to DATA. If DATA_LEN=0, go to IDLE instead with `done`.
- **DATA:**
  - Each `sym_en` drives `BPSK`=`data_in`, `BPSK_vld`=1, and increments the bit counter.
  - If `data_vld`=0 on that cycle: drive `BPSK`=0, pulse `underrun`. The bit still counts; the packet length is preserved.
  - After DATA_LEN bits, go to IDLE and pulse `done`.
- **Return to IDLE:**
  - On the next `sym_en` after the final symbol, `BPSK_vld` and `BPSK` return to 0.
  - `busy` drops in the cycle after `done`.
- `start` while `busy` is ignored, with no queuing. A `start` in the same cycle `done` pulses is also ignored.
- **Counters:** a MAX_TRN_WIDTH TRN counter compares for equality with length-1 and never wraps past it. The LEN_WIDTH data counter behaves the same way. The maximum lengths 2^W-1 must work without overflow.
- **Reset mid-operation:** `rst`=0 in any state forces IDLE and all outputs to 0 on that edge, regardless of `sym_en`. No `done` is issued.

## Timing
- `start` to first symbol: the first symbol appears on `BPSK` in the `clk` after the first `sym_en` that is at least one cycle after `start` was accepted.
- Outputs are stable between `sym_en` pulses. They change only on the edge following a `sym_en` cycle, except reset.
- Total packet length: PRE_LEN + POST_LEN + DATA_LEN symbols, back to back, with no idle symbols.
- The boundary symbol is always the (PRE_LEN+1)-th symbol.
- `done` is asserted in the same edge that registers the final symbol.
- With `sym_en` tied high, the block streams one symbol per `clk`. This case must work.

## Test plan
- PRE=6, POST=4, DATA=4 with data 1,0,0,1, `sym_en` every 4 clk:
  - `BPSK` = 0 1 0 1 0 1 | 1 0 1 0 | 1 0 0 1.
  - `HDR_pos` is high for exactly the first 6 symbols.
  - `done` pulses once; `busy` lasts 14 symbol periods plus the arm latency.
- PRE=5, POST=3, DATA=0, `sym_en` tied high:
  - `BPSK` = 0 1 0 1 0 | 0 1 0.
  - `done` coincides with the 8th symbol; `data_rdy` never asserts.
- PRE=0, POST=0:
  - Both are treated as 1; `BPSK` = 0 | 0, then the payload.
- DATA=3 with `data_vld` low on the 2nd bit:
  - The 2nd payload symbol is 0, with one `underrun` pulse.
  - The length is still 3 symbols and `done` is on time.
- `start` re-asserted mid-packet:
  - It is ignored and the packet content is unchanged.
  - A `start` one cycle after `busy` falls launches a second, identical packet.
- `rst`=0 asserted during POST:
  - On that edge all outputs are 0 and the state is IDLE.
  - A subsequent `start` produces a full, correct frame from symbol 0.
